// File: rtl/dp_acc_pkg.sv
// rtl/dp_acc_pkg.sv - shared widths and state type for the dot-product accumulator
//
// Purpose : operand and product widths used by the multiplier and the
//           accumulator, plus the accumulator state encoding.
// Contents: OP_W, PROD_W, acc_state_t

package dp_acc_pkg;

    // Operand width of each streamed multiplicand / multiplier.
    localparam int OP_W   = 4;
    // Full unsigned product width of an OP_W x OP_W multiply.
    localparam int PROD_W = 2 * OP_W;

    // ACC_EMPTY: no partial vector held (acc, cnt, ovf all zero).
    // ACC_BUSY : at least one non-last element of a vector has been summed.
    typedef enum logic {
        ACC_EMPTY,
        ACC_BUSY
    } acc_state_t;

endpackage

// File: rtl/main.sv
// rtl/main.sv - 4x4 unsigned combinational multiplier
//
// Purpose : full-precision unsigned product of two OP_W-bit operands.
// Ports   :
//   x  in  OP_W    unsigned multiplicand
//   y  in  OP_W    unsigned multiplier
//   o  out PROD_W  x * y, never truncated

module main
    import dp_acc_pkg::*;
(
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   y,
    output logic [PROD_W-1:0] o
);

    // Both operands widened first so the multiply is evaluated at product width.
    assign o = PROD_W'(x) * PROD_W'(y);

endmodule

// File: rtl/dot_product_acc.sv
// rtl/dot_product_acc.sv - streamed 4-bit multiply-accumulate with vector framing
//
// Purpose : accepts (x, y, last) pairs over valid/ready, multiplies each pair,
//           sums the products of one vector and presents sum/length/overflow
//           on a valid/ready result port.
// Pipeline: stage A (operand reg) -> main multiplier -> stage P (product reg)
//           -> accumulator -> result register.
// Ports   :
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      operand pair can be accepted (combinational)
//   in_x       in   OP_W   unsigned multiplicand
//   in_y       in   OP_W   unsigned multiplier
//   in_last    in   1      final element of its vector
//   out_valid  out  1      result register holds a completed vector
//   out_ready  in   1      downstream consumes the result
//   out_sum    out  ACC_W  sum of products modulo 2^ACC_W
//   out_len    out  LEN_W  element count, saturating at all-ones
//   out_ovf    out  1      some accumulate of the vector carried out of ACC_W

module dot_product_acc
    import dp_acc_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_x,
    input  logic [OP_W-1:0]  in_y,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [LEN_W-1:0] out_len,
    output logic             out_ovf
);

    // Stage A
    logic              a_vld_q,  a_vld_d;
    logic [OP_W-1:0]   a_x_q,    a_x_d;
    logic [OP_W-1:0]   a_y_q,    a_y_d;
    logic              a_last_q, a_last_d;

    // Stage P
    logic              p_vld_q,  p_vld_d;
    logic [PROD_W-1:0] p_prod_q, p_prod_d;
    logic              p_last_q, p_last_d;

    // Accumulator
    acc_state_t        state_q,  state_d;
    logic [ACC_W-1:0]  acc_q,    acc_d;
    logic [LEN_W-1:0]  cnt_q,    cnt_d;
    logic              ovf_q,    ovf_d;

    // Result register
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_sum_q,   out_sum_d;
    logic [LEN_W-1:0]  out_len_q,   out_len_d;
    logic              out_ovf_q,   out_ovf_d;

    logic [PROD_W-1:0] mul_o;
    logic              stall;
    logic              in_fire;
    logic              consume;
    logic [ACC_W:0]    sum_ext;
    logic [LEN_W-1:0]  cnt_inc;
    logic              ovf_new;

    main u_mul (
        .x (a_x_q),
        .y (a_y_q),
        .o (mul_o)
    );

    // Only a last product can block: it needs the result register, which is
    // busy when a previous result is still unconsumed this cycle.
    assign stall   = p_vld_q && p_last_q && out_valid_q && !out_ready;
    assign in_ready = !a_vld_q || !stall;
    assign in_fire = in_valid && in_ready;
    assign consume = p_vld_q && !stall;

    // One extra bit captures the carry out of the ACC_W-bit sum.
    assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(p_prod_q);
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
    assign ovf_new = ovf_q | sum_ext[ACC_W];

    always_comb begin
        a_vld_d     = a_vld_q;
        a_x_d       = a_x_q;
        a_y_d       = a_y_q;
        a_last_d    = a_last_q;
        p_vld_d     = p_vld_q;
        p_prod_d    = p_prod_q;
        p_last_d    = p_last_q;
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_len_d   = out_len_q;
        out_ovf_d   = out_ovf_q;

        // Stage A: load on handshake; otherwise it empties whenever the
        // pipeline advances (its content has moved into P).
        if (in_fire) begin
            a_vld_d  = 1'b1;
            a_x_d    = in_x;
            a_y_d    = in_y;
            a_last_d = in_last;
        end else if (!stall) begin
            a_vld_d  = 1'b0;
        end

        // Stage P: captures the multiplier output whenever not stalled.
        if (!stall) begin
            p_vld_d  = a_vld_q;
            p_prod_d = mul_o;
            p_last_d = a_last_q;
        end

        // Pop first; a same-edge load below overrides it and keeps valid high.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (consume) begin
            if (p_last_q) begin
                out_valid_d = 1'b1;
                out_sum_d   = sum_ext[ACC_W-1:0];
                out_len_d   = cnt_inc;
                out_ovf_d   = ovf_new;
                state_d     = ACC_EMPTY;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                state_d     = ACC_BUSY;
                acc_d       = sum_ext[ACC_W-1:0];
                cnt_d       = cnt_inc;
                ovf_d       = ovf_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_q     <= 1'b0;
            a_x_q       <= '0;
            a_y_q       <= '0;
            a_last_q    <= 1'b0;
            p_vld_q     <= 1'b0;
            p_prod_q    <= '0;
            p_last_q    <= 1'b0;
            state_q     <= ACC_EMPTY;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_len_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            a_vld_q     <= a_vld_d;
            a_x_q       <= a_x_d;
            a_y_q       <= a_y_d;
            a_last_q    <= a_last_d;
            p_vld_q     <= p_vld_d;
            p_prod_q    <= p_prod_d;
            p_last_q    <= p_last_d;
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_len_q   <= out_len_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_len   = out_len_q;
    assign out_ovf   = out_ovf_q;

endmodule
